// File: rtl/pcie_tlp_arbiter.sv
// pcie_tlp_arbiter: round-robin sharing of a single-TLP endpoint port among
// N_REQ requesters. One TLP in flight; IDLE -> ISSUE -> WAIT -> CPL -> IDLE.
// A missing endpoint response turns into an error completion after TIMEOUT
// WAIT cycles.
module pcie_tlp_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*32-1:0] req_tlp,
  output logic [N_REQ-1:0]    req_ready,
  output logic [31:0]         ep_tlp_data,
  output logic                ep_tlp_valid,
  input  logic [31:0]         ep_rsp_data,
  input  logic                ep_rsp_valid,
  output logic [N_REQ-1:0]    cpl_valid,
  output logic [31:0]         cpl_data,
  output logic                cpl_err,
  output logic                busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CPL   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_gnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_ep_data;
  logic               r_ep_valid;
  logic [N_REQ-1:0]   r_cpl_valid;
  logic [31:0]        r_cpl_data;
  logic               r_cpl_err;
  logic               r_busy;

  logic               w_found;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [IDX_W:0]     w_pos;
  logic [31:0]        w_tlp;
  logic [N_REQ-1:0]   w_ready;
  logic               w_timeout;

  // Round-robin search: first valid requester starting at r_rr_ptr, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_pos     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(N_REQ)) w_pos = w_pos - (IDX_W+1)'(N_REQ);
      if (!w_found && req_valid[w_pos[IDX_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_pos[IDX_W-1:0];
      end
    end
  end

  // Select the winning requester's TLP slice and build the one-hot ready.
  always_comb begin
    w_tlp   = '0;
    w_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == IDX_W'(i)) w_tlp = req_tlp[32*i +: 32];
    end
    if (r_state == S_IDLE && w_found) w_ready[w_gnt_idx] = 1'b1;
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a response in the timeout cycle still counts as a response.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (ep_rsp_valid || w_timeout) w_next = S_CPL;
      S_CPL:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; strobes are loaded on entry to the state
  // that owns them so they line up with ISSUE and CPL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_ep_data   <= '0;
      r_ep_valid  <= 1'b0;
      r_cpl_valid <= '0;
      r_cpl_data  <= '0;
      r_cpl_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ep_valid  <= 1'b0;
      r_cpl_valid <= '0;
      r_busy      <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt      <= w_gnt_idx;
            r_ep_data  <= w_tlp;
            r_ep_valid <= 1'b1;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (ep_rsp_valid) begin
            r_cpl_data  <= ep_rsp_data;
            r_cpl_err   <= 1'b0;
            r_cpl_valid <= N_REQ'(1) << r_gnt;
          end else if (w_timeout) begin
            r_cpl_data  <= 32'hFFFF_FFFF;
            r_cpl_err   <= 1'b1;
            r_cpl_valid <= N_REQ'(1) << r_gnt;
          end
        end
        S_CPL: begin
          r_rr_ptr <= (r_gnt == IDX_W'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = w_ready;
  assign ep_tlp_data  = r_ep_data;
  assign ep_tlp_valid = r_ep_valid;
  assign cpl_valid    = r_cpl_valid;
  assign cpl_data     = r_cpl_data;
  assign cpl_err      = r_cpl_err;
  assign busy         = r_busy;

endmodule

// File: tb/tb_pcie_tlp_arbiter.sv
// Bench for pcie_tlp_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model (round-robin pick + fixed latency).
module tb_pcie_tlp_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_tlp;
  logic [N-1:0]    req_ready;
  logic [31:0]     ep_tlp_data;
  logic            ep_tlp_valid;
  logic [31:0]     ep_rsp_data;
  logic            ep_rsp_valid;
  logic [N-1:0]    cpl_valid;
  logic [31:0]     cpl_data;
  logic            cpl_err;
  logic            busy;

  pcie_tlp_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tlp(req_tlp),
    .req_ready(req_ready), .ep_tlp_data(ep_tlp_data), .ep_tlp_valid(ep_tlp_valid),
    .ep_rsp_data(ep_rsp_data), .ep_rsp_valid(ep_rsp_valid), .cpl_valid(cpl_valid),
    .cpl_data(cpl_data), .cpl_err(cpl_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] tlp [N];
  logic [N-1:0] pend;
  int          rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic drive_req();
    req_valid = pend;
    for (int i = 0; i < N; i++) req_tlp[32*i +: 32] = tlp[i];
  endtask

  // One transaction starting at a negedge in IDLE. L = endpoint latency in
  // cycles after the TLP strobe (<=0: no response). keep = requests stay up.
  task automatic txn(input int L, input logic [31:0] rdata, input bit keep);
    int g, e;
    logic [31:0] xd;
    logic        xe;
    g  = pick(pend, rr);
    e  = (L >= 1 && L <= TO) ? L : TO;
    xd = (L >= 1 && L <= TO) ? rdata : 32'hFFFF_FFFF;
    xe = !(L >= 1 && L <= TO);
    drive_req();
    #1;
    chk("req_ready_idle", 32'(req_ready), 32'(1) << g);
    chk("busy_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ep_tlp_valid", 32'(ep_tlp_valid), 32'd1);
    chk("ep_tlp_data", ep_tlp_data, tlp[g]);
    chk("busy_issue", 32'(busy), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (!keep) pend[g] = 1'b0;
    tlp[g] = $urandom;
    drive_req();
    for (int n = 1; n <= e + 1; n++) begin
      @(negedge clk);
      if (n <= e) begin
        chk("cpl_quiet", 32'(cpl_valid), 32'd0);
        chk("ep_tlp_once", 32'(ep_tlp_valid), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);
      end else begin
        chk("cpl_valid", 32'(cpl_valid), 32'(1) << g);
        chk("cpl_data", cpl_data, xd);
        chk("cpl_err", 32'(cpl_err), 32'(xe));
        chk("busy_cpl", 32'(busy), 32'd1);
      end
      ep_rsp_valid = (n == L);
      ep_rsp_data  = (n == L) ? rdata : $urandom;
    end
    @(negedge clk);
    chk("cpl_drop", 32'(cpl_valid), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
    chk("cpl_data_hold", cpl_data, xd);
    chk("cpl_err_hold", 32'(cpl_err), 32'(xe));
    rr = (g + 1) % N;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pend = '0; rr = 0;
    ep_rsp_valid = 1'b0; ep_rsp_data = '0;
    for (int i = 0; i < N; i++) tlp[i] = $urandom;
    drive_req();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_ep_valid", 32'(ep_tlp_valid), 32'd0);
    chk("rst_ep_data", ep_tlp_data, 32'd0);
    chk("rst_cpl_valid", 32'(cpl_valid), 32'd0);
    chk("rst_cpl_data", cpl_data, 32'd0);
    chk("rst_cpl_err", 32'(cpl_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // All requesters held high from reset: grants rotate 0,1,2,3,0,1.
    pend = 4'hF;
    for (int i = 0; i < 6; i++) txn(1, $urandom, 1'b1);
    pend = '0; drive_req();
    @(negedge clk);

    // Config read from requester 2.
    pend = 4'b0100; tlp[2] = 32'h8000_0000;
    txn(1, 32'h1234_5678, 1'b0);

    // Requester 1 alone, then 1 and 3 together: 3 wins, then 1.
    pend = 4'b0010; txn(2, $urandom, 1'b0);
    pend = 4'b1010; txn(1, $urandom, 1'b0);
    txn(3, $urandom, 1'b0);

    // Silent endpoint -> timeout completion, then a stray response is ignored.
    pend = 4'b0001; txn(0, 32'h0, 1'b0);
    ep_rsp_valid = 1'b1; ep_rsp_data = 32'hA5A5_5A5A;
    @(negedge clk);
    ep_rsp_valid = 1'b0;
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_cpl", 32'(cpl_valid), 32'd0);
    chk("stray_data", cpl_data, 32'hFFFF_FFFF);
    chk("stray_err", 32'(cpl_err), 32'd1);
    @(negedge clk);
    chk("stray_busy2", 32'(busy), 32'd0);

    // Response in the same cycle as the timeout: response wins.
    pend = 4'b0010; txn(TO, $urandom, 1'b0);

    // Payloads forwarded unmodified.
    pend = 4'b1000; tlp[3] = 32'h0009_0000; txn(2, 32'hDEAD_DEAD, 1'b0);
    pend = 4'b0001; txn(3, 32'h0000_0001, 1'b0);

    // Randomized traffic with growing/shrinking pending sets.
    for (int i = 0; i < 24; i++) begin
      pend = pend | 4'($urandom);
      if (pend == '0) pend[$urandom_range(0, N-1)] = 1'b1;
      txn(int'($urandom_range(1, 6)), $urandom, 1'b0);
    end
    pend = '0; drive_req();
    @(negedge clk);

    // Reset during WAIT: drops the TLP, round-robin restarts at 0.
    pend = 4'b0100; txn(1, $urandom, 1'b0);
    pend = 4'b0010; drive_req();
    #1;
    chk("rstw_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    chk("rstw_issue", 32'(ep_tlp_valid), 32'd1);
    pend = '0; drive_req();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_cpl", 32'(cpl_valid), 32'd0);
    chk("rstw_ep_valid", 32'(ep_tlp_valid), 32'd0);
    chk("rstw_ep_data", ep_tlp_data, 32'd0);
    chk("rstw_cpl_data", cpl_data, 32'd0);
    ep_rsp_valid = 1'b1; ep_rsp_data = 32'h7777_7777;
    @(negedge clk);
    ep_rsp_valid = 1'b0;
    chk("rstw_late_cpl", 32'(cpl_valid), 32'd0);
    chk("rstw_late_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rstw_late_cpl2", 32'(cpl_valid), 32'd0);
    rr = 0;
    pend = 4'b1001; txn(1, $urandom, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
